muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_datapath.sv | 92 +++++++++
 rtl/muldiv_sequencer.sv | 102 ++++++++++
 tb/tb_muldiv_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and defaults for the multiply/divide unit
// Purpose: sequencer state encoding, default operand width, and the
//          control-unit opcode set that drives the sequencer.
// Ports:   none (package)
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    FINISH   = 2'd3
  } state_t;

  // Opcodes decoded by the main control unit; MFHI/MFLO read hi/lo directly.
  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_MFHI = 2'd2,
    OP_MFLO = 2'd3
  } op_t;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add multiply / restoring divide registers
// Purpose: holds operand magnitudes and signs, performs one iteration per
//          step, and applies sign correction on fix.
// Ports:   clk, reset     - clock, async active-high reset
//          load, is_div   - latch a/b (mode selected by is_div)
//          step           - one multiply or divide iteration
//          fix            - apply sign correction to the result
//          a, b           - raw signed operands
//          result         - {hi, lo} working value
module muldiv_datapath import muldiv_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 is_div,
  input  logic                 step,
  input  logic                 fix,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result
);

  logic               div_mode;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   opb;   // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc;   // mult: {partial, multiplier}; div: {rem, quot}

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [2*WIDTH-1:0] fixed;

  // MIN maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mult_next = {sum, acc[WIDTH-1:1]};

  // Remainder stays below the divisor, so the W-bit subtract never wraps
  // when it is kept.
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, opb});
  assign diff     = shifted[WIDTH-1:0] - opb;
  assign div_next = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                       : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign rem  = acc[2*WIDTH-1:WIDTH];
  assign quot = acc[WIDTH-1:0];

  // A negated 2^(WIDTH-1) quotient wraps to MIN naturally.
  always_comb begin
    fixed = acc;
    if (div_mode) begin
      fixed = {(sa ? -rem : rem), ((sa ^ sb) ? -quot : quot)};
    end else if (sa ^ sb) begin
      fixed = -acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_mode <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      opb      <= '0;
      acc      <= '0;
    end else if (load) begin
      div_mode <= is_div;
      sa       <= a[WIDTH-1];
      sb       <= b[WIDTH-1];
      opb      <= is_div ? b_mag : a_mag;
      acc      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
    end else if (step) begin
      acc <= div_mode ? div_next : mult_next;
    end else if (fix) begin
      acc <= fixed;
    end
  end

  assign result = acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle signed multiply/divide sequencer
// Purpose: FSM, iteration counter and start/done handshake around the
//          muldiv datapath; owns the architectural hi/lo registers.
// Ports:   clk, reset              - clock, async active-high reset
//          start_mult, start_div   - operation requests (sampled in IDLE)
//          a, b                    - signed operands
//          busy, done, div_zero    - status (registered)
//          hi, lo                  - product halves / remainder, quotient
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] result;
  logic               b_zero;
  logic               load;
  logic               step;
  logic               fix;

  assign b_zero = (b == '0);
  assign load   = (state == IDLE) && (start_mult || (start_div && !b_zero));
  assign step   = (state == MULT_RUN) || (state == DIV_RUN);
  // FINISH spends its first cycle on sign correction, its second on loading hi/lo.
  assign fix    = (state == FINISH) && (count == '0);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .is_div (!start_mult),
    .step   (step),
    .fix    (fix),
    .a      (a),
    .b      (b),
    .result (result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (start_mult) begin
            state <= MULT_RUN;
          end else if (start_div) begin
            if (b_zero) div_zero <= 1'b1;
            else        state    <= DIV_RUN;
          end
        end
        MULT_RUN, DIV_RUN: begin
          busy <= 1'b1;
          if (count == LAST) begin
            state <= FINISH;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        FINISH: begin
          if (count == '0) begin
            count <= CW'(1);
          end else begin
            hi    <= result[2*WIDTH-1:WIDTH];
            lo    <= result[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            count <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          sm;
    bit          sd;
    bit          poke;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is positioned at a negedge in a cycle where the DUT is idle
  // (or in its done cycle); returns at the negedge of the done cycle.
  task automatic run_op(input vec_t v, input string name);
    int edges;
    int busy_cycles;
    bit overlap;
    bit dz;
    start_mult = v.sm;
    start_div  = v.sd;
    a = v.a;
    b = v.b;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    edges = 0;
    busy_cycles = 0;
    overlap = 1'b0;
    dz = 1'b0;
    while (!done && edges < 100) begin
      if (busy) busy_cycles++;
      if (div_zero) dz = 1'b1;
      if (v.poke && edges == 5) begin
        start_div = 1'b1;
        start_mult = 1'b1;
        a = 32'h0;
        b = 32'h0;
      end
      if (v.poke && edges == 8) begin
        start_div = 1'b0;
        start_mult = 1'b0;
      end
      @(negedge clk);
      edges++;
      if (busy && done) overlap = 1'b1;
    end
    check($sformatf("%s latency", name), 32'(edges), 32'd34);
    check($sformatf("%s busy_cycles", name), 32'(busy_cycles), 32'd33);
    check($sformatf("%s hi", name), hi, v.hi);
    check($sformatf("%s lo", name), lo, v.lo);
    check($sformatf("%s busy_done_overlap", name), 32'(overlap), 32'd0);
    check($sformatf("%s div_zero", name), 32'(dz), 32'd0);
  endtask

  initial begin
    int n_done;
    int n_busy;

    reset = 1'b1;
    start_mult = 1'b0;
    start_div = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //            sm    sd    poke  a             b             hi            lo
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h00000007, 32'h00000003, 32'h00000001, 32'h00000002};

    // Each operation after the first is started in the previous done cycle.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    @(negedge clk);
    check("done one-cycle pulse", 32'(done), 32'd0);

    // Divide by zero with hi=1, lo=2 held from the last vector.
    start_div = 1'b1;
    a = 32'd5;
    b = 32'd0;
    @(negedge clk);
    start_div = 1'b0;
    check("divzero pulse", 32'(div_zero), 32'd1);
    check("divzero busy", 32'(busy), 32'd0);
    check("divzero done", 32'(done), 32'd0);
    @(negedge clk);
    check("divzero pulse width", 32'(div_zero), 32'd0);
    n_done = 0;
    n_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("divzero no done", 32'(n_done), 32'd0);
    check("divzero no busy", 32'(n_busy), 32'd0);
    check("divzero hi kept", hi, 32'h1);
    check("divzero lo kept", lo, 32'h2);

    // Reset ten cycles into a multiply.
    start_mult = 1'b1;
    a = 32'd7;
    b = 32'd3;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset hi", hi, 32'h0);
    check("async reset lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("aborted op no done", 32'(n_done), 32'd0);
    check("aborted op hi", hi, 32'h0);
    run_op('{1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14}, "post-reset div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
